// File: rtl/oled_fsm.sv
// oled_fsm: control FSM for the soda-machine OLED text path.
// Steps through clear, price, cents, coin-total and dispense text loads.
// Each state asserts one load strobe for the registers that feed the OLED
// character writer. The strobes are decoded from the state register only.
// Optional macro OLED_FSM_PB_EDGE_EN: pb3 and pb2 advance the FSM only on
// a rising edge. When the macro is undefined, both buttons act on level.
module oled_fsm (
   input  logic clk,
   input  logic rst,
   input  logic pb3,
   input  logic pb2,
   input  logic d,
   input  logic char_done,
   output logic clr_reg,
   output logic ld_price,
   output logic ld_cents,
   output logic ld_coins,
   output logic ld_disp
);

   typedef enum logic [6:0] {
      INIT      = 7'b0000001,
      IDLE      = 7'b0000010,
      WR_PRICE  = 7'b0000100,
      WAIT_COIN = 7'b0001000,
      WR_CENTS  = 7'b0010000,
      WR_COINS  = 7'b0100000,
      DISP      = 7'b1000000
   } state_t;

   state_t state;
   state_t state_nxt;

   logic   start_go;
   logic   coin_go;

`ifdef OLED_FSM_PB_EDGE_EN
   logic pb3_q;
   logic pb2_q;

   // Previous button levels, used for rising-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pb3_q <= 1'b0;
         pb2_q <= 1'b0;
      end else begin
         pb3_q <= pb3;
         pb2_q <= pb2;
      end
   end

   assign start_go = pb3 & ~pb3_q;
   assign coin_go  = pb2 & ~pb2_q;
`else
   assign start_go = pb3;
   assign coin_go  = pb2;
`endif

   // State register; a low rst forces INIT at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= INIT;
      else      state <= state_nxt;
   end

   // Next-state logic and Moore output decode; any non-one-hot code returns to INIT
   always_comb begin
      state_nxt = INIT;
      clr_reg   = 1'b0;
      ld_price  = 1'b0;
      ld_cents  = 1'b0;
      ld_coins  = 1'b0;
      ld_disp   = 1'b0;
      case (state)
         INIT: begin
            clr_reg   = 1'b1;
            state_nxt = IDLE;
         end
         IDLE: begin
            state_nxt = start_go ? WR_PRICE : IDLE;
         end
         WR_PRICE: begin
            ld_price  = 1'b1;
            state_nxt = char_done ? WAIT_COIN : WR_PRICE;
         end
         WAIT_COIN: begin
            state_nxt = coin_go ? WR_CENTS : WAIT_COIN;
         end
         WR_CENTS: begin
            ld_cents  = 1'b1;
            state_nxt = char_done ? WR_COINS : WR_CENTS;
         end
         WR_COINS: begin
            ld_coins = 1'b1;
            if (char_done) state_nxt = d ? DISP : WR_PRICE;
            else           state_nxt = WR_COINS;
         end
         DISP: begin
            ld_disp   = 1'b1;
            state_nxt = char_done ? INIT : DISP;
         end
         default: begin
            state_nxt = INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_oled_fsm.sv
// tb_oled_fsm: scoreboard bench for oled_fsm.
// The stimulus process pushes the expected strobes for each clock edge.
// A separate monitor pops those expectations and compares them with the outputs.
// When OLED_FSM_PB_EDGE_EN is defined, the model also qualifies the buttons on rising edges.
module tb_oled_fsm;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pb3 = 1'b0;
   logic pb2 = 1'b0;
   logic d = 1'b0;
   logic char_done = 1'b0;
   logic clr_reg, ld_price, ld_cents, ld_coins, ld_disp;

   always #5 clk = ~clk;

   oled_fsm dut (
      .clk(clk), .rst(rst), .pb3(pb3), .pb2(pb2), .d(d), .char_done(char_done),
      .clr_reg(clr_reg), .ld_price(ld_price), .ld_cents(ld_cents),
      .ld_coins(ld_coins), .ld_disp(ld_disp)
   );

   // Phases of a sale as seen by the customer
   localparam int P_INIT  = 0;
   localparam int P_IDLE  = 1;
   localparam int P_PRICE = 2;
   localparam int P_WAIT  = 3;
   localparam int P_CENTS = 4;
   localparam int P_COINS = 5;
   localparam int P_DISP  = 6;

   int checks   = 0;
   int failures = 0;
   logic [4:0] exp_q[$];
   int   phase = P_INIT;
   logic prev3 = 1'b0;
   logic prev2 = 1'b0;

   // Strobe pattern {clr, price, cents, coins, disp} shown during each phase
   function automatic logic [4:0] strobes(input int p);
      logic [4:0] table_v [7];
      table_v = '{5'b10000, 5'b00000, 5'b01000, 5'b00000, 5'b00100, 5'b00010, 5'b00001};
      return table_v[p];
   endfunction

   // Sale progression: what event each phase waits for, and where it leads
   function automatic int advance(input int p, input logic start, input logic coin,
                                  input logic paid, input logic done);
      int r;
      r = p;
      if (p == P_INIT)                  r = P_IDLE;
      else if (p == P_IDLE  && start)   r = P_PRICE;
      else if (p == P_PRICE && done)    r = P_WAIT;
      else if (p == P_WAIT  && coin)    r = P_CENTS;
      else if (p == P_CENTS && done)    r = P_COINS;
      else if (p == P_COINS && done)    r = paid ? P_DISP : P_PRICE;
      else if (p == P_DISP  && done)    r = P_INIT;
      return r;
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the negedge and queue the expected strobes after the next posedge
   task automatic step(input logic r, input logic b3, input logic b2,
                       input logic dd, input logic cd);
      logic start, coin;
      @(negedge clk);
      rst = r; pb3 = b3; pb2 = b2; d = dd; char_done = cd;
      if (!r) begin
         phase = P_INIT;
         prev3 = 1'b0;
         prev2 = 1'b0;
      end else begin
`ifdef OLED_FSM_PB_EDGE_EN
         start = b3 & ~prev3;
         coin  = b2 & ~prev2;
`else
         start = b3;
         coin  = b2;
`endif
         prev3 = b3;
         prev2 = b2;
         phase = advance(phase, start, coin, dd, cd);
      end
      exp_q.push_back(strobes(phase));
   endtask

   // Assert reset mid-cycle; the outputs must respond without waiting for a clock edge
   task automatic mid_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("async_reset", {clr_reg, ld_price, ld_cents, ld_coins, ld_disp}, 5'b10000);
      phase = P_INIT;
      prev3 = 1'b0;
      prev2 = 1'b0;
   endtask

   // Monitor: compares each posedge's strobes against the oldest expectation
   initial begin
      logic [4:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("strobes", {clr_reg, ld_price, ld_cents, ld_coins, ld_disp}, e);
         end
      end
   end

   initial begin
      #1 rst = 1'b0;
      // Reset held, then released
      repeat (5) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      // Full sale, paid in one coin
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 1, 1);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      // Partial payment returns to the price line, then a second coin completes the sale
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 1, 1, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0);
      // Reset while the dispense message is showing
      mid_reset();
      step(0, 0, 0, 0, 0);
      // pb3 held from before reset release, then toggled
      step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      repeat (4) step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 1);
      repeat (3) step(1, 0, 1, 0, 0);
      // Randomised traffic with occasional synchronous and asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) != 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
              $urandom_range(1) == 1, $urandom_range(2) != 0);
         if ($urandom_range(149) == 0) mid_reset();
      end
      step(1, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound on total run time
   initial begin
      #1000000;
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/oled_fsm.md
Name: oled_fsm

Overview:
- Control FSM for the soda-machine OLED text path.
- Sequences which display-register group is loaded: clear, price line, cents-entered line, coin-total line, final "dispense" message.
- Driven by the pushbuttons pb3 (select/start) and pb2 (coin insert), the dispense-ready flag d, and char_done from the OLED character writer.
- Its outputs are load strobes for the text/data registers feeding that writer.

Parameters:
- None. State encoding is internal: one-hot, 7 states.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; low forces state INIT immediately.
- pb3  input  1  start/select button (already debounced, synchronous to clk).
- pb2  input  1  coin-insert button (already debounced, synchronous to clk).
- d  input  1  dispense condition from the datapath: coins total >= price.
- char_done  input  1  OLED writer has finished the current line.
- clr_reg  output  1  clear all display/data registers.
- ld_price  output  1  load price text into display buffer.
- ld_cents  output  1  load inserted-cents text.
- ld_coins  output  1  load running coin-total text.
- ld_disp  output  1  load dispense message.

Behaviour:
- Moore machine. Outputs are decoded from the state register only, so they are glitch-free. At most one output is high at any time.
- Reset: while rst=0, state=INIT, clr_reg=1, all other outputs 0. Release is synchronous to the next clk edge; reset takes effect mid-operation from any state.
- INIT: clr_reg=1. Next state IDLE, unconditional, 1 cycle.
- IDLE: all outputs 0. pb3=1 -> WR_PRICE; otherwise stay.
- WR_PRICE: ld_price=1. char_done=1 -> WAIT_COIN; otherwise stay.
- WAIT_COIN: all outputs 0. pb2=1 -> WR_CENTS; otherwise stay. pb3 is ignored here.
- WR_CENTS: ld_cents=1. char_done=1 -> WR_COINS; otherwise stay.
- WR_COINS: ld_coins=1. On char_done=1:
  - d=1 -> DISP.
  - d=0 -> WR_PRICE, which refreshes the price line, then waits for the next coin.
  - Otherwise stay.
- DISP: ld_disp=1. char_done=1 -> INIT, which clears registers for the next sale; otherwise stay.
- Priority: only one condition is examined per state, so simultaneous inputs (e.g. pb3 and pb2 both high) follow the rules above for the current state.
- char_done held high continuously advances one state per clock through consecutive write states.
- Latency: every transition takes exactly 1 clock after the condition is sampled high at a rising edge.
- Illegal/unreachable one-hot codes -> INIT on the next edge.

Optional Feature:
- Macro OLED_FSM_PB_EDGE_EN.
- Defined:
  - pb3 and pb2 are registered internally; only a rising edge (current=1, previous=0) qualifies the IDLE->WR_PRICE and WAIT_COIN->WR_CENTS transitions.
  - A button held through a whole sale therefore registers once.
  - The edge registers reset to 0 asynchronously with rst.
- Undefined: pb3 and pb2 are level-sensitive as described in Behaviour.

Test Plan:
1. Hold rst=0 for 5 cycles -> clr_reg=1, other outputs 0. Release rst -> next cycle IDLE, all outputs 0.
2. IDLE, pb3=1 -> next cycle ld_price=1. Then char_done=1 -> WAIT_COIN with all outputs 0. Then pb2=1, char_done=0 -> ld_cents=1.
3. Full sale with d=1: after WR_CENTS, char_done=1 -> ld_coins=1. With char_done=1, d=1 -> ld_disp=1. With char_done=1 -> clr_reg=1 for 1 cycle, then IDLE.
4. Partial payment: in WR_COINS with char_done=1, d=0 -> ld_price=1 (back to WR_PRICE). Then char_done=1 -> WAIT_COIN.
5. Reset mid-operation: assert rst=0 while ld_disp=1 -> clr_reg=1 and ld_disp=0 within the same cycle, without waiting for clk.
6. With OLED_FSM_PB_EDGE_EN defined, pb3 held high continuously from reset release -> FSM stays in IDLE. Toggling pb3 0->1 -> ld_price=1.
